// File: rtl/music_box_mode_sequencer_if.sv
// Muxed SDRAM command bus between the mode sequencer and the SDRAM controller.
// The sequencer drives it (master); the controller consumes it (slave).
interface music_box_mode_sequencer_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] sdram_inputAddress;
  logic [DATA_W-1:0] sdram_writeData;
  logic              sdram_isWriting;
  logic              sdram_inputValid;

  modport master (
    output sdram_inputAddress,
    output sdram_writeData,
    output sdram_isWriting,
    output sdram_inputValid
  );

  modport slave (
    input sdram_inputAddress,
    input sdram_writeData,
    input sdram_isWriting,
    input sdram_inputValid
  );
endinterface

// File: rtl/music_box_mode_sequencer.sv
// Music box mode sequencer: picks a mode from active-low buttons, runs it
// until complete/abort/timeout, routes its SDRAM commands and mixes its audio
// with the live overlay into a saturated, registered DAC sample.
module music_box_mode_sequencer #(
  parameter int                   NUM_MODES       = 4,
  parameter int                   AUDIO_W         = 8,
  parameter int                   ADDR_W          = 25,
  parameter int                   DATA_W          = 16,
  parameter logic [NUM_MODES-1:0] SDRAM_MODE_MASK = 4'b1100,
  parameter int                   TIMEOUT_CYCLES  = 0,
  parameter int                   STATE_W         = $clog2(NUM_MODES + 2)
) (
  input  logic                         clock_50Mhz,
  input  logic                         reset_n,
  input  logic [NUM_MODES-1:0]         mode_request_n,
  input  logic                         abort_n,
  input  logic [NUM_MODES-1:0]         mode_complete,
  input  logic [NUM_MODES*AUDIO_W-1:0] mode_audio,
  input  logic [AUDIO_W-1:0]           overlay_audio,
  input  logic [NUM_MODES*ADDR_W-1:0]  mode_sdram_addr,
  input  logic [NUM_MODES*DATA_W-1:0]  mode_sdram_wdata,
  input  logic [NUM_MODES-1:0]         mode_sdram_wr,
  input  logic [NUM_MODES-1:0]         mode_sdram_valid,
  music_box_mode_sequencer_if.master   sdram,
  output logic [NUM_MODES-1:0]         mode_run,
  output logic [STATE_W-1:0]           state_code,
  output logic [1:0]                   exit_code,
  output logic [AUDIO_W-1:0]           audio_out
);

  localparam int MODE_W  = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
  localparam int CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  localparam logic [1:0] EXIT_COMPLETE = 2'd1;
  localparam logic [1:0] EXIT_ABORT    = 2'd2;
  localparam logic [1:0] EXIT_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_END,
    S_WAIT_RELEASE
  } state_t;

  state_t             state_q, state_d;
  logic [MODE_W-1:0]  mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         exit_q, exit_d;
  logic [AUDIO_W-1:0] audio_q, audio_d;

  logic               any_req;
  logic [MODE_W-1:0]  sel_mode;
  logic               timeout_hit;
  logic [AUDIO_W-1:0] run_sample;
  logic [AUDIO_W:0]   audio_sum;

  assign any_req     = ~&mode_request_n;
  // Watchdog is compiled out functionally when TIMEOUT_CYCLES is 0.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST));

  // Highest-index pressed button wins: later loop iterations overwrite earlier ones.
  always_comb begin
    sel_mode = '0;
    for (int i = 0; i < NUM_MODES; i++) begin
      if (!mode_request_n[i]) sel_mode = MODE_W'(i);
    end
  end

  // State register, current mode, watchdog counter, exit code and DAC sample.
  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      cnt_q   <= '0;
      exit_q  <= 2'd0;
      audio_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      exit_q  <= exit_d;
      audio_q <= audio_d;
    end
  end

  // Next-state logic: mode selection, exit priority and retrigger blocking.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    exit_d  = exit_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_RUN;
          mode_d  = sel_mode;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mode_complete[mode_q]) begin
          state_d = S_END;
          exit_d  = EXIT_COMPLETE;
        end else if (!abort_n) begin
          state_d = S_END;
          exit_d  = EXIT_ABORT;
        end else if (timeout_hit) begin
          state_d = S_END;
          exit_d  = EXIT_TIMEOUT;
        end
      end
      S_END: begin
        state_d = any_req ? S_WAIT_RELEASE : S_IDLE;
      end
      S_WAIT_RELEASE: begin
        if (!any_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Decoded outputs and SDRAM mux; everything is gated by the registered RUN state
  // so nothing leaks once the mode has exited. WAIT_RELEASE reports code 0.
  always_comb begin
    mode_run                 = '0;
    state_code               = '0;
    sdram.sdram_inputAddress = '0;
    sdram.sdram_writeData    = '0;
    sdram.sdram_isWriting    = 1'b0;
    sdram.sdram_inputValid   = 1'b0;
    case (state_q)
      S_RUN: begin
        mode_run[mode_q] = 1'b1;
        state_code       = STATE_W'(mode_q) + STATE_W'(1);
        if (SDRAM_MODE_MASK[mode_q]) begin
          sdram.sdram_inputAddress = mode_sdram_addr[mode_q*ADDR_W +: ADDR_W];
          sdram.sdram_writeData    = mode_sdram_wdata[mode_q*DATA_W +: DATA_W];
          sdram.sdram_isWriting    = mode_sdram_wr[mode_q];
          sdram.sdram_inputValid   = mode_sdram_valid[mode_q];
        end
      end
      S_END: state_code = STATE_W'(NUM_MODES + 1);
      default: ;
    endcase
  end

  // Audio mix: running mode's sample plus overlay, saturated to full scale.
  always_comb begin
    run_sample = (state_q == S_RUN) ? mode_audio[mode_q*AUDIO_W +: AUDIO_W] : '0;
    audio_sum  = {1'b0, run_sample} + {1'b0, overlay_audio};
    audio_d    = audio_sum[AUDIO_W] ? {AUDIO_W{1'b1}} : audio_sum[AUDIO_W-1:0];
  end

  assign exit_code = exit_q;
  assign audio_out = audio_q;

endmodule

// File: tb/tb_music_box_mode_sequencer.sv
// Directed bench: one default instance (watchdog off) and one with a
// 10-cycle watchdog share the same stimulus.
module tb_music_box_mode_sequencer;
  localparam int NM = 4;
  localparam int AW = 8;
  localparam int ADW = 25;
  localparam int DW = 16;
  localparam int SW = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NM-1:0]     mode_request_n;
  logic              abort_n;
  logic [NM-1:0]     mode_complete;
  logic [NM*AW-1:0]  mode_audio;
  logic [AW-1:0]     overlay_audio;
  logic [NM*ADW-1:0] mode_sdram_addr;
  logic [NM*DW-1:0]  mode_sdram_wdata;
  logic [NM-1:0]     mode_sdram_wr;
  logic [NM-1:0]     mode_sdram_valid;

  logic [NM-1:0] run0, run1;
  logic [SW-1:0] sc0, sc1;
  logic [1:0]    ec0, ec1;
  logic [AW-1:0] au0, au1;

  int checks = 0;
  int errors = 0;

  music_box_mode_sequencer_if #(.ADDR_W(ADW), .DATA_W(DW)) sd0 ();
  music_box_mode_sequencer_if #(.ADDR_W(ADW), .DATA_W(DW)) sd1 ();

  always #5 clk = ~clk;

  music_box_mode_sequencer #(.TIMEOUT_CYCLES(0)) dut0 (
    .clock_50Mhz(clk), .reset_n(reset_n), .mode_request_n(mode_request_n),
    .abort_n(abort_n), .mode_complete(mode_complete), .mode_audio(mode_audio),
    .overlay_audio(overlay_audio), .mode_sdram_addr(mode_sdram_addr),
    .mode_sdram_wdata(mode_sdram_wdata), .mode_sdram_wr(mode_sdram_wr),
    .mode_sdram_valid(mode_sdram_valid), .sdram(sd0), .mode_run(run0),
    .state_code(sc0), .exit_code(ec0), .audio_out(au0)
  );

  music_box_mode_sequencer #(.TIMEOUT_CYCLES(10)) dut1 (
    .clock_50Mhz(clk), .reset_n(reset_n), .mode_request_n(mode_request_n),
    .abort_n(abort_n), .mode_complete(mode_complete), .mode_audio(mode_audio),
    .overlay_audio(overlay_audio), .mode_sdram_addr(mode_sdram_addr),
    .mode_sdram_wdata(mode_sdram_wdata), .mode_sdram_wr(mode_sdram_wr),
    .mode_sdram_valid(mode_sdram_valid), .sdram(sd1), .mode_run(run1),
    .state_code(sc1), .exit_code(ec1), .audio_out(au1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int run_cnt;
    reset_n          = 1'b0;
    mode_request_n   = '1;
    abort_n          = 1'b1;
    mode_complete    = '0;
    mode_audio       = '0;
    overlay_audio    = '0;
    mode_sdram_addr  = '0;
    mode_sdram_wdata = '0;
    mode_sdram_wr    = '0;
    mode_sdram_valid = '0;
    step();
    step();
    check("rst_state_code", 32'(sc0), 32'd0);
    check("rst_mode_run", 32'(run0), 32'd0);
    check("rst_exit_code", 32'(ec0), 32'd0);
    check("rst_audio", 32'(au0), 32'd0);
    check("rst_sdram_valid", 32'(sd0.sdram_inputValid), 32'd0);
    check("rst_sdram_addr", 32'(sd0.sdram_inputAddress), 32'd0);
    reset_n = 1'b1;
    step();

    // Priority select: modes 0 and 2 pressed -> mode 2
    mode_request_n = 4'b1010;
    step();
    mode_request_n = 4'b1111;
    check("prio_state_code", 32'(sc0), 32'd3);
    check("prio_mode_run", 32'(run0), 32'b0100);
    abort_n = 1'b0;
    step();
    abort_n = 1'b1;
    check("abort_state_end", 32'(sc0), 32'd5);
    check("abort_exit_code", 32'(ec0), 32'd2);
    step();
    check("abort_back_idle", 32'(sc0), 32'd0);
    check("abort_exit_hold", 32'(ec0), 32'd2);

    // SDRAM gating on mode 3 (mask 1), audio saturation, complete/abort collision
    mode_sdram_valid = 4'b1111;
    mode_sdram_wr    = 4'b1111;
    mode_sdram_addr[3*ADW +: ADW] = 25'h1ABCDE;
    mode_sdram_addr[0*ADW +: ADW] = 25'h0012345;
    mode_sdram_wdata[3*DW +: DW]  = 16'hBEEF;
    mode_sdram_wdata[0*DW +: DW]  = 16'h1111;
    mode_request_n = 4'b0111;
    step();
    mode_request_n = 4'b1111;
    check("m3_state_code", 32'(sc0), 32'd4);
    check("m3_mode_run", 32'(run0), 32'b1000);
    check("m3_sdram_addr", 32'(sd0.sdram_inputAddress), 32'h1ABCDE);
    check("m3_sdram_wdata", 32'(sd0.sdram_writeData), 32'hBEEF);
    check("m3_sdram_wr", 32'(sd0.sdram_isWriting), 32'd1);
    check("m3_sdram_valid", 32'(sd0.sdram_inputValid), 32'd1);
    mode_sdram_addr[3*ADW +: ADW] = 25'h0000123;
    #1;
    check("m3_sdram_addr_comb", 32'(sd0.sdram_inputAddress), 32'h123);
    mode_audio[3*AW +: AW] = 8'd200;
    overlay_audio = 8'd100;
    step();
    check("audio_saturate", 32'(au0), 32'd255);
    mode_complete = 4'b1000;
    abort_n = 1'b0;
    step();
    mode_complete = '0;
    abort_n = 1'b1;
    check("collide_state_end", 32'(sc0), 32'd5);
    check("collide_exit_code", 32'(ec0), 32'd1);
    check("end_sdram_valid", 32'(sd0.sdram_inputValid), 32'd0);
    check("end_mode_run", 32'(run0), 32'd0);
    step();
    check("collide_idle", 32'(sc0), 32'd0);
    check("audio_overlay_only", 32'(au0), 32'd100);
    overlay_audio = 8'd37;
    step();
    check("audio_idle_37", 32'(au0), 32'd37);

    // Mode 0 (mask 0): SDRAM blocked; hold button through complete
    mode_request_n = 4'b1110;
    step();
    check("m0_state_code", 32'(sc0), 32'd1);
    check("m0_mode_run", 32'(run0), 32'b0001);
    check("m0_sdram_valid", 32'(sd0.sdram_inputValid), 32'd0);
    check("m0_sdram_addr", 32'(sd0.sdram_inputAddress), 32'd0);
    mode_complete = 4'b0001;
    step();
    mode_complete = '0;
    check("m0_end", 32'(sc0), 32'd5);
    check("m0_exit_code", 32'(ec0), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("held_no_rerun", 32'(run0), 32'd0);
    end
    mode_request_n = 4'b1111;
    step();
    check("release_idle", 32'(sc0), 32'd0);
    step();
    check("release_stay_idle", 32'(run0), 32'd0);

    // Reset mid-RUN during an SDRAM write on mode 3
    mode_request_n = 4'b0111;
    step();
    mode_request_n = 4'b1111;
    check("pre_rst_valid", 32'(sd0.sdram_inputValid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(sd0.sdram_inputValid), 32'd0);
    check("rst_async_addr", 32'(sd0.sdram_inputAddress), 32'd0);
    check("rst_async_run", 32'(run0), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    check("post_rst_state", 32'(sc0), 32'd0);
    check("post_rst_exit", 32'(ec0), 32'd0);

    // Watchdog: dut1 times out after exactly 10 RUN cycles; dut0 never does
    mode_request_n = 4'b0111;
    step();
    mode_request_n = 4'b1111;
    run_cnt = 0;
    while (sc1 == 3'd4 && run_cnt < 50) begin
      run_cnt++;
      step();
    end
    check("wd_run_cycles", 32'(run_cnt), 32'd10);
    check("wd_end_state", 32'(sc1), 32'd5);
    check("wd_exit_code", 32'(ec1), 32'd3);
    for (int i = run_cnt; i < 1000; i++) step();
    check("nowd_still_run", 32'(sc0), 32'd4);
    check("nowd_mode_run", 32'(run0), 32'b1000);
    check("nowd_exit_code", 32'(ec0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/music_box_mode_sequencer.md
# music_box_mode_sequencer

Parametrised top-level mode sequencer for the music box. It selects one of NUM_MODES user modes (songs, play recording, make recording, etc.) from active-low debounced buttons and runs it until it completes, is aborted, or times out. While a mode runs, the block routes that mode's SDRAM command bus to the shared SDRAM controller and mixes its audio into a registered, saturated DAC sample. It sits between the debouncers/mode blocks and the SDRAM controller/DAC, and replaces per-mode hand-written state decoding with a one-hot run enable.

## Interface
- NUM_MODES, 4, number of selectable modes (1..14); mode k is button/slot k.
- AUDIO_W, 8, DAC sample width (unsigned).
- ADDR_W, 25, SDRAM address width.
- DATA_W, 16, SDRAM data width.
- SDRAM_MODE_MASK, 4'b1100, bit k set means mode k may drive SDRAM.
- TIMEOUT_CYCLES, 0, run watchdog in clock cycles; 0 disables it.
- STATE_W, $clog2(NUM_MODES+2), width of state_code (derived).

Ports:
- clock_50Mhz  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- mode_request_n  in  NUM_MODES  debounced buttons, active low.
- abort_n  in  1  active-low cancel of the running mode.
- mode_complete  in  NUM_MODES  per-mode done level, sampled only for the running mode.
- mode_audio  in  NUM_MODES*AUDIO_W  per-mode samples; slot k is [k*AUDIO_W +: AUDIO_W].
- overlay_audio  in  AUDIO_W  always-mixed live tone.
- mode_sdram_addr / mode_sdram_wdata / mode_sdram_wr / mode_sdram_valid  in  NUM_MODES*ADDR_W / NUM_MODES*DATA_W / NUM_MODES / NUM_MODES  per-mode SDRAM requests.
- sdram_inputAddress / sdram_writeData / sdram_isWriting / sdram_inputValid  out  ADDR_W / DATA_W / 1 / 1  muxed SDRAM command.
- mode_run  out  NUM_MODES  one-hot run enable; all zero when no mode is running.
- state_code  out  STATE_W  0 = idle, k+1 = running mode k, NUM_MODES+1 = end.
- exit_code  out  2  last exit: 0 none, 1 complete, 2 abort, 3 timeout.
- audio_out  out  AUDIO_W  registered, saturated DAC sample.

## Operation
- States: IDLE, RUN, END, WAIT_RELEASE.
- IDLE: if any mode_request_n bit is low, go to RUN with the **highest** low index k latched as the current mode. Otherwise stay in IDLE.
- RUN: leave for END on the first of the following, checked in priority order:
  - mode_complete[k] = 1 gives exit_code 1.
  - abort_n = 0 gives exit_code 2.
  - timeout gives exit_code 3.
  - Simultaneous events resolve by that priority. Buttons are ignored in RUN.
- Watchdog: a cycle counter clears on RUN entry and increments every RUN cycle. The timeout fires on the cycle the counter equals TIMEOUT_CYCLES-1. It is inert when TIMEOUT_CYCLES = 0.
- END: held for exactly one cycle. Next state is WAIT_RELEASE if any button is low, else IDLE.
- WAIT_RELEASE: stay until all mode_request_n bits are 1, then go to IDLE. This blocks retrigger from a held button.
- mode_run[k] = 1 only in RUN with current mode k. It is decoded from registered state.
- SDRAM mux (combinational from registered state):
  - In RUN with SDRAM_MODE_MASK[k] = 1, the outputs equal mode k's slot.
  - Otherwise the outputs are addr 0, wdata 0, wr 0, valid 0. This includes END, so a command can never leak past exit.
- Audio:
  - Compute sum = (RUN ? mode_audio[k] : 0) + overlay_audio at AUDIO_W+1 bits.
  - Saturate to 2^AUDIO_W-1.
  - Register the result into audio_out.
- exit_code holds its value until the next exit and is cleared only by reset.
- Reset values:
  - State is IDLE; current mode is 0; counter is 0.
  - state_code 0, mode_run 0, exit_code 0, audio_out 0.
  - All SDRAM outputs are 0.
- Reset asserted mid-RUN aborts immediately. SDRAM valid drops asynchronously with reset, and exit_code reads 0, not 2.

## Timing
- A button low at edge n gives RUN, mode_run and state_code valid after edge n.
- A complete/abort/timeout seen at edge m gives END after edge m, and IDLE or WAIT_RELEASE after edge m+1.
- The minimum IDLE-to-IDLE trip is 3 cycles (RUN, END, then IDLE).
- SDRAM outputs follow the mode inputs combinationally while in RUN, with zero added latency.
- audio_out has 1-cycle latency from mode_audio/overlay_audio.
- With a timeout, RUN lasts exactly TIMEOUT_CYCLES cycles.

## Test plan
- **Priority select:** mode_request_n = 4'b1010 in IDLE (low on modes 0 and 2) → next cycle state_code = 3, mode_run = 4'b0100.
- **SDRAM gating:** run mode 3 (mask 1) with valid = 1 and addr 0x1ABCDE → outputs match. Run mode 0 (mask 0) with valid = 1 → sdram_inputValid = 0, address 0. In END → valid = 0.
- **Complete/abort collision:** mode_complete[3] and abort_n = 0 on the same cycle → END, exit_code = 1, then IDLE one cycle later.
- **Watchdog:** TIMEOUT_CYCLES = 10, no complete → exactly 10 RUN cycles, exit_code = 3. With TIMEOUT_CYCLES = 0 → stays in RUN for 1000 cycles.
- **Retrigger and saturation:** hold the button through complete → WAIT_RELEASE until release, with no second RUN. mode_audio = 200 plus overlay 100 → audio_out = 255 one cycle later. In IDLE, overlay 37 → 37.
- **Reset mid-RUN:** assert reset_n low during an SDRAM write → all outputs 0 immediately, state_code 0 and exit_code 0 after release.
